// File: rtl/bch_decoder.sv
// Bit-serial BCH(63,56) decoder: syndrome S0 (parity) and S1 (GF(64), p(x)=x^6+x+1),
// then a Chien-style search that corrects a single error in the latched word.
module bch_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [62:0] R,
    output logic [62:0] C_out,
    output logic [55:0] D,
    output logic [1:0]  status,
    output logic        Decode_Done,
    output logic [2:0]  dbg_state
);

    // Handshake: R is sampled on the first IDLE edge that sees start=1. Decode_Done
    // stays high in DONE until start is seen low, so one start level yields one decode.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYN  = 3'd1,
        EVAL = 3'd2,
        SRCH = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_FIXED = 2'b01;
    localparam logic [1:0] ST_UNCOR = 2'b10;

    state_t      state_q, state_d;
    logic [62:0] w_q, w_d;
    logic        s0_q, s0_d;
    logic [5:0]  s1_q, s1_d;
    logic [5:0]  k_q, k_d;
    logic [5:0]  e_q, e_d;
    logic [5:0]  i_q, i_d;
    logic [1:0]  status_q, status_d;
    logic        done_q, done_d;

    // Multiply a GF(64) element by alpha: x^6 folds back as x+1.
    function automatic logic [5:0] mul_alpha(input logic [5:0] v);
        return {v[4:0], 1'b0} ^ (v[5] ? 6'b000011 : 6'b000000);
    endfunction

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        k_d      = k_q;
        e_d      = e_q;
        i_d      = i_q;
        status_d = status_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = R;
                    s0_d    = 1'b0;
                    s1_d    = 6'd0;
                    k_d     = 6'd62;
                    state_d = SYN;
                end
            end
            SYN: begin
                // Horner evaluation from the top bit down leaves S1 = sum W[i]*alpha^i.
                s0_d = s0_q ^ w_q[k_q];
                s1_d = mul_alpha(s1_q) ^ {5'b00000, w_q[k_q]};
                if (k_q == 6'd0) begin
                    state_d = EVAL;
                end else begin
                    k_d = k_q - 6'd1;
                end
            end
            EVAL: begin
                if (!s0_q && (s1_q == 6'd0)) begin
                    status_d = ST_OK;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (s0_q && (s1_q != 6'd0)) begin
                    e_d     = 6'd1;
                    i_d     = 6'd0;
                    state_d = SRCH;
                end else begin
                    status_d = ST_UNCOR;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            SRCH: begin
                // alpha has order 63, so e walks every nonzero element and must hit S1.
                if (e_q == s1_q) begin
                    w_d      = w_q ^ (63'd1 << i_q);
                    status_d = ST_FIXED;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    e_d = mul_alpha(e_q);
                    i_d = i_q + 6'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            w_q      <= 63'd0;
            s0_q     <= 1'b0;
            s1_q     <= 6'd0;
            k_q      <= 6'd0;
            e_q      <= 6'd0;
            i_q      <= 6'd0;
            status_q <= ST_OK;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            k_q      <= k_d;
            e_q      <= e_d;
            i_q      <= i_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign C_out       = w_q;
    assign D           = w_q[62:7];
    assign status      = status_q;
    assign Decode_Done = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bch_decoder.sv
// Randomized scoreboard bench for bch_decoder; the reference model decodes with
// GF(64) power/log tables and polynomial division instead of a serial datapath.
module tb_bch_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [62:0] R;
    logic [62:0] C_out;
    logic [55:0] D;
    logic [1:0]  status;
    logic        Decode_Done;
    logic [2:0]  dbg_state;

    bch_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .R           (R),
        .C_out       (C_out),
        .D           (D),
        .status      (status),
        .Decode_Done (Decode_Done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int checks = 0;
    int errors = 0;

    logic [62:0] exp_q[$];
    logic [1:0]  exp_stat_q[$];
    int          exp_lat_q[$];
    int          exp_t0_q[$];

    logic [5:0] pow_t[0:62];
    int         log_t[0:63];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: S0 = parity, S1 = sum of alpha^i; one error at log(S1) when S0=1.
    task automatic model(input logic [62:0] r, output logic [62:0] w,
                         output logic [1:0] st, output int lat);
        logic       s0;
        logic [5:0] s1;
        int         j;
        s0 = ^r;
        s1 = 6'd0;
        for (int b = 0; b < 63; b++) if (r[b]) s1 ^= pow_t[b];
        w = r;
        if (!s0 && s1 == 6'd0) begin
            st = 2'b00; lat = 64;
        end else if (s0 && s1 != 6'd0) begin
            j = log_t[s1];
            w[j] = ~w[j];
            st = 2'b01; lat = 65 + j;
        end else begin
            st = 2'b10; lat = 64;
        end
    endtask

    function automatic logic [62:0] encode(input logic [55:0] data);
        logic [62:0] rem;
        rem = {data, 7'd0};
        for (int b = 62; b >= 7; b--) if (rem[b]) rem ^= (63'h0C5 << (b - 7));
        return {data, rem[6:0]};
    endfunction

    // Monitor: each rising Decode_Done pops one expected result.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (Decode_Done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [62:0] ew;
                logic [1:0]  es;
                int          el, t0;
                ew = exp_q.pop_front();
                es = exp_stat_q.pop_front();
                el = exp_lat_q.pop_front();
                t0 = exp_t0_q.pop_front();
                check("c_out", C_out, ew);
                check("data", D, ew[62:7]);
                check("status", status, es);
                check("latency", cycle_cnt - t0, el);
            end
        end
        done_prev = Decode_Done;
    end

    task automatic push_exp(input logic [62:0] ew, input logic [1:0] es, input int el, input int t0);
        exp_q.push_back(ew);
        exp_stat_q.push_back(es);
        exp_lat_q.push_back(el);
        exp_t0_q.push_back(t0);
    endtask

    // Waits for completion, holds start for `hold` cycles, then releases it.
    task automatic finish_decode(input logic [62:0] ew, input int hold);
        int n = 0;
        while (!Decode_Done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!Decode_Done) begin
            check("done_timeout", 64'd0, 64'd1);
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(exp_stat_q.pop_back());
                void'(exp_lat_q.pop_back());
                void'(exp_t0_q.pop_back());
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_held", Decode_Done, 1);
            check("no_retrigger", C_out, ew);
        end
        start = 1'b0;
        R     = {$urandom(), $urandom()};
        @(negedge clk);
        check("done_pulse_end", Decode_Done, 0);
        check("idle_keeps_word", C_out, ew);
    endtask

    task automatic run(input logic [62:0] r, input logic [62:0] ew, input logic [1:0] es,
                       input int el, input int hold, input int drop_after);
        @(negedge clk);
        R     = r;
        start = 1'b1;
        push_exp(ew, es, el, cycle_cnt + 1);
        if (drop_after > 0) begin
            repeat (drop_after) @(negedge clk);
            start = 1'b0;
        end
        finish_decode(ew, hold);
    endtask

    task automatic run_model(input logic [62:0] r, input int hold);
        logic [62:0] ew;
        logic [1:0]  es;
        int          el;
        model(r, ew, es, el);
        run(r, ew, es, el, hold, 0);
    endtask

    initial begin
        logic [6:0]  v;
        logic [62:0] cw, r;
        logic [62:0] ew;
        logic [1:0]  es;
        int          el, p1, p2, kind;

        v = 7'd1;
        for (int b = 0; b < 63; b++) begin
            pow_t[b] = v[5:0];
            v = v << 1;
            if (v[6]) v ^= 7'h43;
        end
        for (int b = 0; b < 64; b++) log_t[b] = 0;
        for (int b = 0; b < 63; b++) log_t[pow_t[b]] = b;

        rst_n = 1'b0;
        start = 1'b0;
        R     = 63'd0;
        repeat (2) @(negedge clk);
        check("rst_c_out", C_out, 0);
        check("rst_d", D, 0);
        check("rst_status", status, 0);
        check("rst_done", Decode_Done, 0);
        rst_n = 1'b1;

        // Directed vectors with hand-derived expectations.
        run(63'h0, 63'h0, 2'b00, 64, 4, 0);
        run(63'h0C5, 63'h0C5, 2'b00, 64, 1, 0);
        run(63'h0C5 ^ (63'd1 << 40), 63'h0C5, 2'b01, 105, 0, 0);
        run(63'h3, 63'h3, 2'b10, 64, 0, 0);
        run(63'h7, 63'h4000007, 2'b01, 91, 2, 0);
        run(63'h0C5 ^ (63'd1 << 40), 63'h0C5, 2'b01, 105, 0, 70);

        for (int i = 0; i < 63; i++) begin
            run(63'd1 << i, 63'h0, 2'b01, 65 + i, 0, 0);
            run(63'h0C5 ^ (63'd1 << i), 63'h0C5, 2'b01, 65 + i, 0, 0);
        end

        // Reset during SYN, start held through release.
        @(negedge clk);
        R     = 63'h0C5 ^ (63'd1 << 10);
        start = 1'b1;
        repeat (31) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_c_out", C_out, 0);
        check("midrst_d", D, 0);
        check("midrst_status", status, 0);
        check("midrst_done", Decode_Done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(63'h0C5, 2'b01, 75, cycle_cnt + 1);
        finish_decode(63'h0C5, 0);

        for (int t = 0; t < 40; t++) begin
            cw   = encode({$urandom(), $urandom()});
            kind = $urandom_range(0, 3);
            p1   = $urandom_range(0, 62);
            p2   = (p1 + $urandom_range(1, 62)) % 63;
            case (kind)
                0: r = cw;
                1: r = cw ^ (63'd1 << p1);
                2: r = cw ^ (63'd1 << p1) ^ (63'd1 << p2);
                default: r = {$urandom(), $urandom()};
            endcase
            if (kind == 1) begin
                model(r, ew, es, el);
                check("model_single_fix", ew, cw);
            end
            run_model(r, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
